// File: rtl/clock_pkg.sv
// Shared constants and helpers for the BCD clock counter chain.
package clock_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned MAX_DIGITS  = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam int unsigned TICK_DIV_1S = 125_000_000;
  localparam int unsigned MOD_SEC     = 60;
  localparam int unsigned MOD_HOUR    = 24;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Binary to packed BCD, digit 0 in bits [3:0]; used only on constants.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    logic [DIGIT_W*MAX_DIGITS-1:0] r = '0;
    int unsigned v = value;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_bcd_digit.sv
// One BCD digit register with up/down step, carry/borrow chaining and load.
module updown_bcd_digit
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               cin_i,
  input  logic               dec_i,
  output logic               cout_o,
  output logic [DIGIT_W-1:0] digit_o
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // cin_i is the step enable for this digit; cout_o ripples it onward on 9->0 / 0->9.
  assign cout_o  = cin_i & (dec_i ? (digit_q == '0) : (digit_q == BCD_MAX));
  assign digit_o = digit_q;

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = load_val_i;
    end else if (cin_i) begin
      if (dec_i) digit_d = (digit_q == '0) ? BCD_MAX : digit_q - DIGIT_W'(1);
      else       digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + DIGIT_W'(1);
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

endmodule

// File: rtl/updown_bcd_counter.sv
// Multi-digit BCD up/down counter with programmable modulus, tick prescaler,
// manual step, validated parallel load and a wrap pulse for cascading.
module updown_bcd_counter
  import clock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned MODULUS    = 60,
  parameter int unsigned TICK_DIV   = 125_000_000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          EN,
  input  logic                          DEC,
  input  logic                          STEP,
  input  logic                          CLR,
  input  logic                          LOAD,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] LOAD_VAL,
  output logic [DIGIT_W*NUM_DIGITS-1:0] COUNT,
  output logic                          TICK,
  output logic                          WRAP,
  output logic                          LOAD_ERR
);

  localparam int unsigned   CW         = DIGIT_W * NUM_DIGITS;
  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TOP_BCD    = CW'(to_bcd(MODULUS - 1));

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("updown_bcd_counter: NUM_DIGITS must be in 1..4");
  end
  if (MODULUS < 2 || MODULUS > pow10(NUM_DIGITS)) begin : g_bad_modulus
    $error("updown_bcd_counter: MODULUS must be in 2..10^NUM_DIGITS");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("updown_bcd_counter: TICK_DIV must be >= 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_int;
  logic          tick_q, wrap_q, load_err_q;
  logic          wrap_d, load_err_d;

  assign tick_int = EN && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (CLR || tick_int) presc_d = '0;
    else if (EN)         presc_d = presc_q + PW'(1);
  end

  logic [CW-1:0] count_w;
  logic          step_req, at_top, at_zero, nibbles_ok, load_ok;
  logic          digit_step, load_en;
  logic [CW-1:0] load_data;

  assign step_req = tick_int | STEP;
  assign at_top   = (count_w == TOP_BCD);
  assign at_zero  = (count_w == '0);

  always_comb begin
    nibbles_ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (LOAD_VAL[i*DIGIT_W +: DIGIT_W] > BCD_MAX) nibbles_ok = 1'b0;
    end
  end

  // Valid BCD orders exactly like its raw bits, so a plain compare checks the range.
  assign load_ok = nibbles_ok && (LOAD_VAL <= TOP_BCD);

  // Modulus wrap overrides the digit ripple by loading the opposite end value.
  assign wrap_d     = step_req && !CLR && !LOAD && (DEC ? at_zero : at_top);
  assign digit_step = step_req && !CLR && !LOAD && !wrap_d;
  assign load_en    = (LOAD && load_ok) || wrap_d;
  assign load_data  = wrap_d ? (DEC ? TOP_BCD : '0) : LOAD_VAL;
  assign load_err_d = LOAD && !CLR && !load_ok;

  logic [NUM_DIGITS:0] carry;
  logic                unused_carry_top;

  assign carry[0]         = digit_step;
  assign unused_carry_top = carry[NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    updown_bcd_digit u_digit (
      .clk        (CLK),
      .rst_n      (RESET),
      .clr_i      (CLR),
      .load_i     (load_en),
      .load_val_i (load_data[g*DIGIT_W +: DIGIT_W]),
      .cin_i      (carry[g]),
      .dec_i      (DEC),
      .cout_o     (carry[g+1]),
      .digit_o    (count_w[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_int;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign COUNT    = count_w;
  assign TICK     = tick_q;
  assign WRAP     = wrap_q;
  assign LOAD_ERR = load_err_q;

endmodule

// File: doc/updown_bcd_counter.md
Name: updown_bcd_counter

Overview:
Parametrised successor to the single-digit decade up/down counter. Multi-digit BCD counter with a programmable modulus, such as 60 for seconds/minutes or 24 for hours, and a built-in tick prescaler. Also supports a manual step, a parallel load with validity check, and a wrap pulse for cascading. Instances are chained through WRAP/STEP to build the clock's sec/min/hour chain.

Parameters:
NUM_DIGITS, 2, number of BCD digits; legal range 1..4
MODULUS, 60, count range 0..MODULUS-1; legal range 2..10^NUM_DIGITS
TICK_DIV, 125000000, CLK cycles per automatic step; legal >=1 (1 means step every enabled cycle)

Ports:
CLK  in  1  system clock; all state on rising edge
RESET  in  1  asynchronous, active-low reset; low clears all state immediately
EN  in  1  enables the prescaler; when low, the prescaler holds its value
DEC  in  1  direction; 0 counts up, 1 counts down; sampled on each step
STEP  in  1  manual single step, one cycle per step; independent of EN
CLR  in  1  synchronous clear of value and prescaler
LOAD  in  1  synchronous parallel load request
LOAD_VAL  in  4*NUM_DIGITS  BCD value to load; digit 0 in bits [3:0]
COUNT  out  4*NUM_DIGITS  registered BCD count value
TICK  out  1  registered one-cycle pulse when the prescaler reaches its terminal count
WRAP  out  1  registered one-cycle pulse on up wrap (MODULUS-1 to 0) or down wrap (0 to MODULUS-1)
LOAD_ERR  out  1  registered one-cycle pulse when a LOAD was rejected

Behaviour:
- Reset (RESET=0): COUNT=0, prescaler=0, TICK=0, WRAP=0, LOAD_ERR=0; asynchronous assertion.
- Prescaler: width max(1, clog2(TICK_DIV)).
  - When EN=1, it increments each cycle.
  - At TICK_DIV-1 it returns to 0 and an internal tick fires the same cycle.
  - TICK output is that tick registered, so it lags by one cycle.
  - When EN=0, the prescaler holds and no tick fires.
- Step request = internal tick OR STEP. If both occur in the same cycle, exactly one step is taken.
- Priority per cycle: CLR > LOAD > step.
  - CLR: COUNT=0, prescaler=0, no WRAP.
  - LOAD: the prescaler is unaffected and any step in the same cycle is discarded.
    - Accepted when every nibble <=9 and the decimal value < MODULUS; COUNT takes LOAD_VAL next cycle.
    - Otherwise COUNT is unchanged and LOAD_ERR pulses next cycle.
  - Step up: at MODULUS-1 the count goes to 0 and WRAP pulses; otherwise +1 with BCD carry (digit 9 to 0 carries into the next digit).
  - Step down: at 0 the count goes to MODULUS-1 and WRAP pulses; otherwise -1 with BCD borrow (digit 0 to 9 borrows from the next digit).
- Latency: COUNT and WRAP update on the clock edge after the step request. WRAP is coincident with the wrapped COUNT value.
- DEC change mid-run: takes effect on the next step; no glitch, no extra step.
- RESET released mid-period: the prescaler restarts from 0; the first tick comes TICK_DIV enabled cycles later.
- COUNT is always valid BCD and < MODULUS after any operation.
- Illegal parameter values are trapped by an elaboration-time check; no runtime behaviour is defined for them.

Decomposition:
Shared package (clock_pkg) holds:
- BCD digit width (4)
- BCD_MAX=9
- the 125 MHz 1-second divide constant
- standard moduli MOD_SEC=60, MOD_HOUR=24

The sub-module updown_bcd_digit is natural: one digit register with inc/dec enable, carry/borrow in and out, and a load value. The top level adds:
- the prescaler
- step arbitration
- modulus compare and wrap override (whole-value compare against MODULUS-1 and 0)
- load validation

Test Plan:
- Reset and step up: NUM_DIGITS=2, MODULUS=60, TICK_DIV=4, EN=1, DEC=0, release RESET → TICK every 4th cycle; COUNT steps 00,01,…,09,10 (BCD carry), then 59→00 with a WRAP pulse in the same cycle COUNT shows 00.
- Step down: DEC=1 from 00 → 59 with WRAP; then 50→49 (BCD borrow); no value >59 is ever observed.
- LOAD accept and reject, with EN=0:
  - LOAD_VAL=0x45 → COUNT=0x45 next cycle, LOAD_ERR=0.
  - LOAD_VAL=0x60 → COUNT stays 0x45, LOAD_ERR pulses.
  - LOAD_VAL=0x3A → COUNT stays 0x45, LOAD_ERR pulses.
- Priority and coincidence:
  - STEP coincident with the internal tick → single increment (0x12→0x13).
  - CLR together with LOAD=0x30 → COUNT=0x00.
  - LOAD with STEP → COUNT=LOAD_VAL, no step.
- Hold and asynchronous reset:
  - EN=0 for 10 cycles at prescaler=2 → no TICK; resumes with TICK after 2 enabled cycles.
  - RESET pulled low mid-cycle → COUNT=0 immediately, no clock edge needed.
- Hours configuration: MODULUS=24, STEP-driven from 23, DEC=0 → 00 with WRAP; DEC=1 from 00 → 23 with WRAP.
